// File: rtl/div_iter_unit_if.sv
// Operand/result handshake bundle for the iterative divider.
// The master side is the issuing pipeline stage; the slave side is the divider.
interface div_iter_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag, cancel, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_tag, busy
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag, cancel, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_tag, busy
  );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// Works on magnitudes and applies the sign fix-up in a single FIX cycle.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  div_iter_unit_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] out_quo_r;
  logic [WIDTH-1:0] out_rem_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             out_valid_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             div_zero_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;

  // Two's complement magnitude; the most negative value maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    if (sgn && v[WIDTH-1]) begin
      r = {WIDTH{1'b0}} - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Handshake decode and one restoring trial subtraction.
  always_comb begin
    in_ready_s = ~reset & ~bus.cancel &
                 ((state_r == IDLE) | ((state_r == DONE) & bus.out_ready));
    accept_s   = bus.in_valid & in_ready_s;
    div_zero_s = (bus.in_divisor == {WIDTH{1'b0}});
    dvd_mag_s  = mag(bus.in_dividend, bus.in_signed);
    dvs_mag_s  = mag(bus.in_divisor, bus.in_signed);
    shift_s    = {rem_r, quo_r[WIDTH-1]};
    diff_s     = shift_s - {1'b0, dvs_r};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; cancel overrides everything, including a pending result.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.cancel) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_nxt_s = div_zero_s ? FIX : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end
        FIX: begin
          state_nxt_s = DONE;
        end
        DONE: begin
          if (accept_s) begin
            state_nxt_s = div_zero_s ? FIX : CALC;
          end else if (bus.out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Operand capture and the shift/subtract iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      // Divide by zero preloads the architectural result and bypasses the fix-up.
      cnt_r   <= CNT_W'(WIDTH - 1);
      rem_r   <= div_zero_s ? bus.in_dividend : {WIDTH{1'b0}};
      quo_r   <= div_zero_s ? {WIDTH{1'b1}} : dvd_mag_s;
      dvs_r   <= dvs_mag_s;
      q_neg_r <= ~div_zero_s & bus.in_signed &
                 (bus.in_dividend[WIDTH-1] ^ bus.in_divisor[WIDTH-1]);
      r_neg_r <= ~div_zero_s & bus.in_signed & bus.in_dividend[WIDTH-1];
      tag_r   <= bus.in_tag;
    end else if (state_r == CALC) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      if (!diff_s[WIDTH]) begin
        rem_r <= diff_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shift_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result registers; data holds across cancel, only the valid flag is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_quo_r   <= {WIDTH{1'b0}};
      out_rem_r   <= {WIDTH{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (bus.cancel) begin
      out_valid_r <= 1'b0;
    end else if (state_r == FIX) begin
      out_quo_r   <= q_neg_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
      out_rem_r   <= r_neg_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
      out_tag_r   <= tag_r;
      out_valid_r <= 1'b1;
    end else if ((state_r == DONE) && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_quotient  = out_quo_r;
  assign bus.out_remainder = out_rem_r;
  assign bus.out_tag       = out_tag_r;
  assign bus.busy          = (state_r != IDLE);

endmodule
